fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 30 +++
 rtl/fetch_unit.sv | 139 +++++++++++++
 tb/tb_fetch_unit.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared fetch unit definitions: bus widths, reset PC, FSM encoding and push payload.
`timescale 1ns/1ps
package fetch_unit_pkg;

    localparam int unsigned INST_BUS_W  = 32;
    localparam int unsigned INST_ADDR_W = 32;
    localparam logic [INST_ADDR_W-1:0] RESET_PC_DEFAULT = 32'hBFC00000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic                   valid1;
        logic [INST_BUS_W-1:0]  inst1;
        logic [INST_ADDR_W-1:0] addr1;
        logic                   valid2;
        logic [INST_BUS_W-1:0]  inst2;
        logic [INST_ADDR_W-1:0] addr2;
    } fetch_push_t;

    // An 8-byte aligned address fetches a pair, otherwise only one word.
    function automatic logic [INST_ADDR_W-1:0] next_fetch_pc(input logic [INST_ADDR_W-1:0] addr);
        return addr + (addr[2] ? INST_ADDR_W'(4) : INST_ADDR_W'(8));
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: issues ICache requests, pushes 1-2 words per response into the instruction buffer.
// Optional FETCH_PERF_CNT_EN adds stall_cnt_o counting backpressure cycles in REQ.
`timescale 1ns/1ps
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [INST_ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic [INST_ADDR_W-1:0] redirect_pc_i,
    output logic                   icache_req_o,
    output logic [INST_ADDR_W-1:0] icache_addr_o,
    input  logic                   icache_ack_i,
    input  logic                   icache_rvalid_i,
    input  logic [INST_BUS_W-1:0]  icache_rdata1_i,
    input  logic [INST_BUS_W-1:0]  icache_rdata2_i,
    input  logic                   buffer_full_i,
    output logic [INST_BUS_W-1:0]  inst1_o,
    output logic [INST_BUS_W-1:0]  inst2_o,
    output logic [INST_ADDR_W-1:0] inst1_addr_o,
    output logic [INST_ADDR_W-1:0] inst2_addr_o,
    output logic                   inst1_valid_o,
    output logic                   inst2_valid_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]            stall_cnt_o
`endif
);

    fetch_state_e           state_q, state_d;
    logic [INST_ADDR_W-1:0] pc_q, pc_d;
    logic [INST_ADDR_W-1:0] req_pc_q, req_pc_d;
    logic                   req_q, req_d;
    logic [INST_ADDR_W-1:0] addr_q, addr_d;
    fetch_push_t            push_q, push_d;
    logic                   handshake;

    assign handshake = req_q & icache_ack_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
            req_q    <= 1'b0;
            addr_q   <= '0;
            push_q   <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            push_q   <= push_d;
        end
    end

    // Next state, request and push generation; push data holds, valids pulse for one cycle.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        req_pc_d      = req_pc_q;
        req_d         = req_q;
        addr_d        = addr_q;
        push_d        = push_q;
        push_d.valid1 = 1'b0;
        push_d.valid2 = 1'b0;

        if (flush) begin
            pc_d  = redirect_pc_i;
            req_d = 1'b0;
            case (state_q)
                WAIT:    state_d = icache_rvalid_i ? REQ : DROP;
                DROP:    state_d = icache_rvalid_i ? REQ : DROP;
                default: state_d = handshake ? DROP : REQ;
            endcase
        end else begin
            case (state_q)
                IDLE: state_d = REQ;
                REQ: begin
                    if (handshake) begin
                        state_d  = WAIT;
                        req_d    = 1'b0;
                        req_pc_d = addr_q;
                        pc_d     = next_fetch_pc(addr_q);
                    end else if (!req_q) begin
                        // A pending request is held; a new one is raised only with buffer room.
                        req_d  = ~buffer_full_i;
                        addr_d = pc_q;
                    end
                end
                WAIT: begin
                    if (icache_rvalid_i) begin
                        state_d       = REQ;
                        push_d.valid1 = 1'b1;
                        push_d.inst1  = icache_rdata1_i;
                        push_d.addr1  = req_pc_q;
                        push_d.valid2 = ~req_pc_q[2];
                        push_d.inst2  = icache_rdata2_i;
                        push_d.addr2  = req_pc_q + INST_ADDR_W'(4);
                    end
                end
                DROP: begin
                    if (icache_rvalid_i) begin
                        state_d = REQ;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign icache_req_o  = req_q;
    assign icache_addr_o = addr_q;
    assign inst1_valid_o = push_q.valid1;
    assign inst1_o       = push_q.inst1;
    assign inst1_addr_o  = push_q.addr1;
    assign inst2_valid_o = push_q.valid2;
    assign inst2_o       = push_q.inst2;
    assign inst2_addr_o  = push_q.addr2;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt_q;

    // Saturating count of REQ cycles blocked by the buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if ((state_q == REQ) && buffer_full_i && (stall_cnt_q != 32'hFFFFFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed fetch, flush, backpressure, wrap and reset scenarios.
`timescale 1ns/1ps
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [31:0] redirect_pc_i;
    logic        icache_req_o;
    logic [31:0] icache_addr_o;
    logic        icache_ack_i;
    logic        icache_rvalid_i;
    logic [31:0] icache_rdata1_i;
    logic [31:0] icache_rdata2_i;
    logic        buffer_full_i;
    logic [31:0] inst1_o, inst2_o, inst1_addr_o, inst2_addr_o;
    logic        inst1_valid_o, inst2_valid_o;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt_o;
`endif

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'hBFC00000)) dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .redirect_pc_i   (redirect_pc_i),
        .icache_req_o    (icache_req_o),
        .icache_addr_o   (icache_addr_o),
        .icache_ack_i    (icache_ack_i),
        .icache_rvalid_i (icache_rvalid_i),
        .icache_rdata1_i (icache_rdata1_i),
        .icache_rdata2_i (icache_rdata2_i),
        .buffer_full_i   (buffer_full_i),
        .inst1_o         (inst1_o),
        .inst2_o         (inst2_o),
        .inst1_addr_o    (inst1_addr_o),
        .inst2_addr_o    (inst2_addr_o),
        .inst1_valid_o   (inst1_valid_o),
        .inst2_valid_o   (inst2_valid_o)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stall_cnt_o     (stall_cnt_o)
`endif
    );

    int          tests = 0;
    int          fails = 0;
    logic [31:0] req_exp_q[$];
    fetch_push_t push_exp_q[$];
    logic [31:0] mon_req_exp;
    fetch_push_t mon_push_exp, mon_push_act;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic fetch_push_t mk_push(input logic [31:0] addr, input logic [31:0] d1,
                                            input logic [31:0] d2);
        fetch_push_t p;
        p.valid1 = 1'b1;
        p.inst1  = d1;
        p.addr1  = addr;
        p.valid2 = ~addr[2];
        p.inst2  = addr[2] ? 32'h0 : d2;
        p.addr2  = addr[2] ? 32'h0 : addr + 32'd4;
        return p;
    endfunction

    // Monitor: every acknowledged request and every push is matched against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (icache_req_o && icache_ack_i) begin
                tests++;
                if (req_exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL req_unexpected: got addr %0h expected no request", icache_addr_o);
                end else begin
                    mon_req_exp = req_exp_q.pop_front();
                    if (icache_addr_o !== mon_req_exp) begin
                        fails++;
                        $display("FAIL req_addr: got %0h expected %0h", icache_addr_o, mon_req_exp);
                    end
                end
            end
            if (inst1_valid_o || inst2_valid_o) begin
                tests++;
                mon_push_act.valid1 = inst1_valid_o;
                mon_push_act.inst1  = inst1_o;
                mon_push_act.addr1  = inst1_addr_o;
                mon_push_act.valid2 = inst2_valid_o;
                mon_push_act.inst2  = inst2_valid_o ? inst2_o : 32'h0;
                mon_push_act.addr2  = inst2_valid_o ? inst2_addr_o : 32'h0;
                if (push_exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL push_unexpected: got v1=%0b a1=%0h v2=%0b a2=%0h expected no push",
                             inst1_valid_o, inst1_addr_o, inst2_valid_o, inst2_addr_o);
                end else begin
                    mon_push_exp = push_exp_q.pop_front();
                    if (mon_push_act !== mon_push_exp) begin
                        fails++;
                        $display("FAIL push: got v1=%0b i1=%0h a1=%0h v2=%0b i2=%0h a2=%0h expected v1=%0b i1=%0h a1=%0h v2=%0b i2=%0h a2=%0h",
                                 mon_push_act.valid1, mon_push_act.inst1, mon_push_act.addr1,
                                 mon_push_act.valid2, mon_push_act.inst2, mon_push_act.addr2,
                                 mon_push_exp.valid1, mon_push_exp.inst1, mon_push_exp.addr1,
                                 mon_push_exp.valid2, mon_push_exp.inst2, mon_push_exp.addr2);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(output int cycles);
        cycles = 0;
        while (!icache_req_o && cycles < 30) begin
            tick();
            cycles++;
        end
        if (!icache_req_o) begin
            tests++;
            fails++;
            $display("FAIL req_timeout: got no request after %0d cycles expected a request", cycles);
        end
    endtask

    task automatic ack_req(input logic [31:0] addr);
        req_exp_q.push_back(addr);
        icache_ack_i = 1'b1;
        tick();
        icache_ack_i = 1'b0;
    endtask

    task automatic respond(input logic [31:0] d1, input logic [31:0] d2);
        icache_rvalid_i = 1'b1;
        icache_rdata1_i = d1;
        icache_rdata2_i = d2;
        tick();
        icache_rvalid_i = 1'b0;
    endtask

    task automatic do_flush(input logic [31:0] target);
        flush         = 1'b1;
        redirect_pc_i = target;
        tick();
        flush         = 1'b0;
    endtask

    // Normal fetch: wait for request, acknowledge, respond after lat cycles, expect the push.
    task automatic fetch(input logic [31:0] addr, input logic [31:0] d1, input logic [31:0] d2,
                         input int lat, output int cycles);
        wait_req(cycles);
        push_exp_q.push_back(mk_push(addr, d1, d2));
        ack_req(addr);
        repeat (lat - 1) tick();
        respond(d1, d2);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},     64'(icache_req_o),  64'(0));
        check({tag, "_addr"},    64'(icache_addr_o), 64'(0));
        check({tag, "_v1"},      64'(inst1_valid_o), 64'(0));
        check({tag, "_v2"},      64'(inst2_valid_o), 64'(0));
        check({tag, "_i1"},      64'(inst1_o),       64'(0));
        check({tag, "_a1"},      64'(inst1_addr_o),  64'(0));
        check({tag, "_i2_a2"},   {inst2_o, inst2_addr_o}, 64'(0));
    endtask

    initial begin
        int c;
        rst = 1'b1; flush = 1'b0; redirect_pc_i = '0; icache_ack_i = 1'b0;
        icache_rvalid_i = 1'b0; icache_rdata1_i = '0; icache_rdata2_i = '0; buffer_full_i = 1'b0;
        repeat (3) tick();
        check_reset_outputs("reset");
`ifdef FETCH_PERF_CNT_EN
        check("reset_stall_cnt", 64'(stall_cnt_o), 64'(0));
`endif
        rst = 1'b0;

        // Reset release: first request two cycles later, dual push, response right after the ack.
        fetch(32'hBFC00000, 32'h11111111, 32'h22222222, 1, c);
        check("first_req_cycle", 64'(c), 64'(2));

        // Backpressure in REQ for five cycles.
        buffer_full_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_req_low", 64'(icache_req_o), 64'(0));
        end
`ifdef FETCH_PERF_CNT_EN
        check("bp_stall_cnt", 64'(stall_cnt_o), 64'(5));
`endif
        buffer_full_i = 1'b0;
        fetch(32'hBFC00008, 32'h33333333, 32'h44444444, 2, c);

        // Flush a pending unacknowledged request, then a misaligned single fetch.
        wait_req(c);
        do_flush(32'h80000004);
        check("flush_drops_req", 64'(icache_req_o), 64'(0));
        fetch(32'h80000004, 32'h55555555, 32'h66666666, 1, c);

        // Flush during WAIT: late response is dropped, redirect target fetched next.
        wait_req(c);
        ack_req(32'h80000008);
        do_flush(32'h80001000);
        repeat (2) tick();
        respond(32'hDEAD0001, 32'hDEAD0002);

        // Flush with same-cycle rvalid: response dropped, redirect used.
        wait_req(c);
        ack_req(32'h80001000);
        flush = 1'b1; redirect_pc_i = 32'hFFFFFFF8;
        respond(32'hDEAD0003, 32'hDEAD0004);
        flush = 1'b0;

        // Wrap around the top of the address space.
        fetch(32'hFFFFFFF8, 32'h77777777, 32'h88888888, 1, c);
        fetch(32'h00000000, 32'h99999999, 32'hAAAAAAAA, 3, c);

        // Flush coinciding with the handshake: the acked response must be discarded.
        wait_req(c);
        req_exp_q.push_back(32'h00000008);
        icache_ack_i = 1'b1; flush = 1'b1; redirect_pc_i = 32'h00000040;
        tick();
        icache_ack_i = 1'b0; flush = 1'b0;
        check("flush_hs_req_low", 64'(icache_req_o), 64'(0));
        tick();
        respond(32'hDEAD0005, 32'hDEAD0006);
        fetch(32'h00000040, 32'hBBBBBBBB, 32'hCCCCCCCC, 1, c);

        // Reset while waiting for a response restarts at the reset PC.
        wait_req(c);
        ack_req(32'h00000048);
        rst = 1'b1;
        tick();
        check_reset_outputs("midwait_rst");
        rst = 1'b0;
        fetch(32'hBFC00000, 32'h12345678, 32'h9ABCDEF0, 1, c);
        check("rst_again_req_cycle", 64'(c), 64'(2));

        repeat (4) tick();
        check("req_queue_empty",  64'(req_exp_q.size()),  64'(0));
        check("push_queue_empty", 64'(push_exp_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
